// File: rtl/gnpd_to_dti_conv.sv
// GNPD <-> DTI stream converter at the TCU node.
// Two-entry skid buffers both ways, threshold-gated response packets.
module gnpd_to_dti_conv #(
  parameter logic [5:0] NODE_ID = 6'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [89:0] req_payload,
  input  logic [5:0]  req_srcid,
  input  logic        req_last,
  output logic        req_threshold,
  output logic        req_tvalid,
  output logic [79:0] req_tdata,
  output logic [9:0]  req_tkeep,
  output logic        req_tlast,
  output logic [5:0]  req_ttid,
  input  logic        req_tready,
  input  logic        rsp_tvalid,
  input  logic [79:0] rsp_tdata,
  input  logic [9:0]  rsp_tkeep,
  input  logic        rsp_tlast,
  input  logic [5:0]  rsp_ttid,
  output logic        rsp_tready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [89:0] rsp_payload,
  output logic [5:0]  rsp_srcid,
  output logic [5:0]  rsp_tgtid,
  output logic        rsp_qos,
  output logic        rsp_last,
  input  logic        rsp_threshold,
  output logic        err_tid_switch
);

  typedef enum logic {IDLE, PKT} rsp_st_e;

  // Request buffer: {payload, srcid, last}
  logic [96:0] rq_in;
  logic [96:0] rq_main_q, rq_main_d;
  logic [96:0] rq_skid_q, rq_skid_d;
  logic        rq_mv_q, rq_mv_d;
  logic        rq_sv_q, rq_sv_d;
  logic        rq_rdy_q, rq_rdy_d;
  logic        rq_thr_q, rq_thr_d;
  logic        rq_push, rq_pop;
  logic        rq_inpkt_q, rq_inpkt_d;
  logic [5:0]  rq_tid_q, rq_tid_d;

  // Response buffer: {tdata, tkeep, ttid, tlast}
  logic [96:0] rs_in;
  logic [96:0] rs_main_q, rs_main_d;
  logic [96:0] rs_skid_q, rs_skid_d;
  logic        rs_mv_q, rs_mv_d;
  logic        rs_sv_q, rs_sv_d;
  logic        rs_rdy_q, rs_rdy_d;
  logic        rs_gate;
  logic        rs_push, rs_pop;
  rsp_st_e     rs_st_q, rs_st_d;
  logic [5:0]  cur_tid_q, cur_tid_d;

  logic        err_q, err_d;

  assign rq_in   = {req_payload, req_srcid, req_last};
  assign rq_push = req_valid && rq_rdy_q;
  assign rq_pop  = rq_mv_q && req_tready;

  assign rs_in   = {rsp_tdata, rsp_tkeep, rsp_ttid, rsp_tlast};
  // Threshold only gates the first beat; mid-packet it is ignored.
  assign rs_gate = (rs_st_q == PKT) || rsp_threshold;
  assign rs_push = rsp_tvalid && rs_rdy_q && rs_gate;
  assign rs_pop  = rs_mv_q && rsp_ready;

  // Request skid next-state; skid only fills while main stalls.
  always_comb begin
    rq_main_d = rq_main_q;
    rq_skid_d = rq_skid_q;
    rq_mv_d   = rq_mv_q;
    rq_sv_d   = rq_sv_q;
    if (rq_pop) begin
      if (rq_sv_q) begin
        rq_main_d = rq_skid_q;
        rq_sv_d   = 1'b0;
      end else if (rq_push) begin
        rq_main_d = rq_in;
      end else begin
        rq_mv_d = 1'b0;
      end
    end else if (rq_push) begin
      if (!rq_mv_q) begin
        rq_main_d = rq_in;
        rq_mv_d   = 1'b1;
      end else begin
        rq_skid_d = rq_in;
        rq_sv_d   = 1'b1;
      end
    end
    rq_rdy_d = !rq_sv_d;
    rq_thr_d = !rq_mv_d;
  end

  // Request buffer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rq_main_q <= '0;
      rq_skid_q <= '0;
      rq_mv_q   <= 1'b0;
      rq_sv_q   <= 1'b0;
      rq_rdy_q  <= 1'b0;
      rq_thr_q  <= 1'b0;
    end else begin
      rq_main_q <= rq_main_d;
      rq_skid_q <= rq_skid_d;
      rq_mv_q   <= rq_mv_d;
      rq_sv_q   <= rq_sv_d;
      rq_rdy_q  <= rq_rdy_d;
      rq_thr_q  <= rq_thr_d;
    end
  end

  // Response skid next-state, same scheme as the request side.
  always_comb begin
    rs_main_d = rs_main_q;
    rs_skid_d = rs_skid_q;
    rs_mv_d   = rs_mv_q;
    rs_sv_d   = rs_sv_q;
    if (rs_pop) begin
      if (rs_sv_q) begin
        rs_main_d = rs_skid_q;
        rs_sv_d   = 1'b0;
      end else if (rs_push) begin
        rs_main_d = rs_in;
      end else begin
        rs_mv_d = 1'b0;
      end
    end else if (rs_push) begin
      if (!rs_mv_q) begin
        rs_main_d = rs_in;
        rs_mv_d   = 1'b1;
      end else begin
        rs_skid_d = rs_in;
        rs_sv_d   = 1'b1;
      end
    end
    rs_rdy_d = !rs_sv_d;
  end

  // Response buffer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_main_q <= '0;
      rs_skid_q <= '0;
      rs_mv_q   <= 1'b0;
      rs_sv_q   <= 1'b0;
      rs_rdy_q  <= 1'b0;
    end else begin
      rs_main_q <= rs_main_d;
      rs_skid_q <= rs_skid_d;
      rs_mv_q   <= rs_mv_d;
      rs_sv_q   <= rs_sv_d;
      rs_rdy_q  <= rs_rdy_d;
    end
  end

  // Packet tracking both ways; tid switches mid-packet raise sticky error.
  always_comb begin
    rs_st_d    = rs_st_q;
    cur_tid_d  = cur_tid_q;
    rq_inpkt_d = rq_inpkt_q;
    rq_tid_d   = rq_tid_q;
    err_d      = err_q;
    if (rs_push) begin
      if (rs_st_q == IDLE) begin
        cur_tid_d = rsp_ttid;
        rs_st_d   = rsp_tlast ? IDLE : PKT;
      end else begin
        if (rsp_ttid != cur_tid_q) err_d = 1'b1;
        if (rsp_tlast) rs_st_d = IDLE;
      end
    end
    if (rq_push) begin
      if (!rq_inpkt_q) rq_tid_d = req_srcid;
      else if (req_srcid != rq_tid_q) err_d = 1'b1;
      rq_inpkt_d = !req_last;
    end
  end

  // Response FSM and packet-tracking state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_st_q    <= IDLE;
      cur_tid_q  <= '0;
      rq_inpkt_q <= 1'b0;
      rq_tid_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      rs_st_q    <= rs_st_d;
      cur_tid_q  <= cur_tid_d;
      rq_inpkt_q <= rq_inpkt_d;
      rq_tid_q   <= rq_tid_d;
      err_q      <= err_d;
    end
  end

  assign req_ready      = rq_rdy_q;
  assign req_threshold  = rq_thr_q;
  assign req_tvalid     = rq_mv_q;
  assign req_tdata      = rq_main_q[96:17];
  assign req_tkeep      = rq_main_q[16:7];
  assign req_ttid       = rq_main_q[6:1];
  assign req_tlast      = rq_main_q[0];

  assign rsp_tready     = rs_rdy_q && rs_gate;
  assign rsp_valid      = rs_mv_q;
  assign rsp_payload    = rs_main_q[96:7];
  assign rsp_tgtid      = rs_main_q[6:1];
  assign rsp_last       = rs_main_q[0];
  assign rsp_srcid      = NODE_ID;
  assign rsp_qos        = 1'b1;
  assign err_tid_switch = err_q;

endmodule

// File: tb/tb_gnpd_to_dti_conv.sv
// Directed bench for gnpd_to_dti_conv.
// One task per scenario, inline checks.
module tb_gnpd_to_dti_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [89:0] req_payload;
  logic [5:0]  req_srcid;
  logic        req_last;
  logic        req_threshold;
  logic        req_tvalid;
  logic [79:0] req_tdata;
  logic [9:0]  req_tkeep;
  logic        req_tlast;
  logic [5:0]  req_ttid;
  logic        req_tready;
  logic        rsp_tvalid;
  logic [79:0] rsp_tdata;
  logic [9:0]  rsp_tkeep;
  logic        rsp_tlast;
  logic [5:0]  rsp_ttid;
  logic        rsp_tready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [89:0] rsp_payload;
  logic [5:0]  rsp_srcid;
  logic [5:0]  rsp_tgtid;
  logic        rsp_qos;
  logic        rsp_last;
  logic        rsp_threshold;
  logic        err_tid_switch;

  int total = 0;
  int bad = 0;

  localparam logic [79:0] A5 = 80'hA5A5_A5A5_A5A5_A5A5_A5A5;

  gnpd_to_dti_conv #(.NODE_ID(6'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_payload(req_payload), .req_srcid(req_srcid),
    .req_last(req_last), .req_threshold(req_threshold),
    .req_tvalid(req_tvalid), .req_tdata(req_tdata),
    .req_tkeep(req_tkeep), .req_tlast(req_tlast),
    .req_ttid(req_ttid), .req_tready(req_tready),
    .rsp_tvalid(rsp_tvalid), .rsp_tdata(rsp_tdata),
    .rsp_tkeep(rsp_tkeep), .rsp_tlast(rsp_tlast),
    .rsp_ttid(rsp_ttid), .rsp_tready(rsp_tready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload(rsp_payload), .rsp_srcid(rsp_srcid),
    .rsp_tgtid(rsp_tgtid), .rsp_qos(rsp_qos),
    .rsp_last(rsp_last), .rsp_threshold(rsp_threshold),
    .err_tid_switch(err_tid_switch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%h exp=0", req_ready); end
    total++; if (rsp_tready !== 1'b0) begin bad++; $display("FAIL rst_rsp_tready got=%h exp=0", rsp_tready); end
    total++; if (req_tvalid !== 1'b0) begin bad++; $display("FAIL rst_req_tvalid got=%h exp=0", req_tvalid); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%h exp=0", rsp_valid); end
    total++; if (req_threshold !== 1'b0) begin bad++; $display("FAIL rst_thr got=%h exp=0", req_threshold); end
    total++; if (err_tid_switch !== 1'b0) begin bad++; $display("FAIL rst_err got=%h exp=0", err_tid_switch); end
    total++; if (req_tdata !== 80'd0) begin bad++; $display("FAIL rst_tdata got=%h exp=0", req_tdata); end
    rst_n = 1'b1;
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_req_ready got=%h exp=1", req_ready); end
    total++; if (req_threshold !== 1'b1) begin bad++; $display("FAIL post_rst_thr got=%h exp=1", req_threshold); end
  endtask

  task automatic test_single_req();
    req_tready = 1'b1;
    req_valid = 1'b1;
    req_payload = {A5, 10'h3FF};
    req_srcid = 6'd5;
    req_last = 1'b1;
    tick();
    req_valid = 1'b0;
    total++; if (req_tvalid !== 1'b1) begin bad++; $display("FAIL sreq_tvalid got=%h exp=1", req_tvalid); end
    total++; if (req_tdata !== A5) begin bad++; $display("FAIL sreq_tdata got=%h exp=%h", req_tdata, A5); end
    total++; if (req_tkeep !== 10'h3FF) begin bad++; $display("FAIL sreq_tkeep got=%h exp=3ff", req_tkeep); end
    total++; if (req_ttid !== 6'd5) begin bad++; $display("FAIL sreq_ttid got=%0d exp=5", req_ttid); end
    total++; if (req_tlast !== 1'b1) begin bad++; $display("FAIL sreq_tlast got=%h exp=1", req_tlast); end
    total++; if (req_threshold !== 1'b0) begin bad++; $display("FAIL sreq_thr_low got=%h exp=0", req_threshold); end
    tick();
    total++; if (req_tvalid !== 1'b0) begin bad++; $display("FAIL sreq_drain got=%h exp=0", req_tvalid); end
    total++; if (req_threshold !== 1'b1) begin bad++; $display("FAIL sreq_thr_back got=%h exp=1", req_threshold); end
  endtask

  task automatic test_rsp_4beat();
    logic [79:0] d;
    rsp_ready = 1'b1;
    rsp_threshold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 80'hBEEF0 + 80'(i);
      rsp_tvalid = 1'b1;
      rsp_tdata = d;
      rsp_tkeep = 10'h3FF;
      rsp_ttid = 6'd9;
      rsp_tlast = (i == 3);
      total++; if (rsp_tready !== 1'b1) begin bad++; $display("FAIL r4_tready%0d got=%h exp=1", i, rsp_tready); end
      tick();
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL r4_valid%0d got=%h exp=1", i, rsp_valid); end
      total++; if (rsp_payload !== {d, 10'h3FF}) begin bad++; $display("FAIL r4_payload%0d got=%h exp=%h", i, rsp_payload, {d, 10'h3FF}); end
      total++; if (rsp_tgtid !== 6'd9) begin bad++; $display("FAIL r4_tgtid%0d got=%0d exp=9", i, rsp_tgtid); end
      total++; if (rsp_last !== (i == 3)) begin bad++; $display("FAIL r4_last%0d got=%h exp=%h", i, rsp_last, (i == 3)); end
    end
    rsp_tvalid = 1'b0;
    rsp_tlast = 1'b0;
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL r4_idle got=%h exp=0", rsp_valid); end
    total++; if (rsp_srcid !== 6'd0) begin bad++; $display("FAIL r4_srcid got=%0d exp=0", rsp_srcid); end
    total++; if (rsp_qos !== 1'b1) begin bad++; $display("FAIL r4_qos got=%h exp=1", rsp_qos); end
    total++; if (err_tid_switch !== 1'b0) begin bad++; $display("FAIL r4_err got=%h exp=0", err_tid_switch); end
  endtask

  task automatic test_backpressure();
    int tx;
    int rx;
    logic in_hs;
    logic out_hs;
    logic [79:0] exp_d;
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc == 5) begin
        total++; if (tx !== 2) begin bad++; $display("FAIL bp_accepted got=%0d exp=2", tx); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%h exp=0", req_ready); end
        total++; if (rx !== 0) begin bad++; $display("FAIL bp_stalled_out got=%0d exp=0", rx); end
      end
      req_tready = (cyc >= 5);
      req_valid = (tx < 6);
      req_payload = {80'h100 + 80'(tx), 10'h3FF};
      req_srcid = 6'd2;
      req_last = (tx == 5);
      #1;
      in_hs = req_valid && req_ready;
      out_hs = req_tvalid && req_tready;
      if (out_hs) begin
        exp_d = 80'h100 + 80'(rx);
        total++; if (req_tdata !== exp_d) begin bad++; $display("FAIL bp_data%0d got=%h exp=%h", rx, req_tdata, exp_d); end
        total++; if (req_tlast !== (rx == 5)) begin bad++; $display("FAIL bp_last%0d got=%h exp=%h", rx, req_tlast, (rx == 5)); end
        rx++;
      end
      tick();
      if (in_hs) tx++;
    end
    req_valid = 1'b0;
    req_last = 1'b0;
    total++; if (rx !== 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", rx); end
    total++; if (req_tvalid !== 1'b0) begin bad++; $display("FAIL bp_tail got=%h exp=0", req_tvalid); end
  endtask

  task automatic test_threshold();
    rsp_ready = 1'b1;
    rsp_threshold = 1'b0;
    rsp_tvalid = 1'b1;
    rsp_tdata = 80'h1;
    rsp_tkeep = 10'h00F;
    rsp_ttid = 6'd4;
    rsp_tlast = 1'b0;
    #1;
    total++; if (rsp_tready !== 1'b0) begin bad++; $display("FAIL thr_idle_block got=%h exp=0", rsp_tready); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL thr_no_accept got=%h exp=0", rsp_valid); end
    rsp_threshold = 1'b1;
    #1;
    total++; if (rsp_tready !== 1'b1) begin bad++; $display("FAIL thr_open got=%h exp=1", rsp_tready); end
    tick();
    rsp_threshold = 1'b0;
    rsp_tdata = 80'h2;
    #1;
    total++; if (rsp_tready !== 1'b1) begin bad++; $display("FAIL thr_beat2 got=%h exp=1", rsp_tready); end
    tick();
    rsp_tdata = 80'h3;
    rsp_tlast = 1'b1;
    #1;
    total++; if (rsp_tready !== 1'b1) begin bad++; $display("FAIL thr_beat3 got=%h exp=1", rsp_tready); end
    tick();
    total++; if (rsp_payload !== {80'h3, 10'h00F}) begin bad++; $display("FAIL thr_beat3_data got=%h exp=%h", rsp_payload, {80'h3, 10'h00F}); end
    total++; if (rsp_last !== 1'b1) begin bad++; $display("FAIL thr_beat3_last got=%h exp=1", rsp_last); end
    rsp_tdata = 80'h4;
    #1;
    total++; if (rsp_tready !== 1'b0) begin bad++; $display("FAIL thr_new_pkt_wait got=%h exp=0", rsp_tready); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL thr_new_pkt_held got=%h exp=0", rsp_valid); end
    rsp_threshold = 1'b1;
    tick();
    rsp_tvalid = 1'b0;
    total++; if (rsp_payload !== {80'h4, 10'h00F}) begin bad++; $display("FAIL thr_new_pkt_data got=%h exp=%h", rsp_payload, {80'h4, 10'h00F}); end
    tick();
    total++; if (err_tid_switch !== 1'b0) begin bad++; $display("FAIL thr_err got=%h exp=0", err_tid_switch); end
  endtask

  task automatic test_tid_switch();
    rsp_ready = 1'b1;
    rsp_threshold = 1'b1;
    rsp_tvalid = 1'b1;
    rsp_tkeep = 10'h3FF;
    rsp_tdata = 80'h31;
    rsp_ttid = 6'd3;
    rsp_tlast = 1'b0;
    tick();
    total++; if (err_tid_switch !== 1'b0) begin bad++; $display("FAIL tid_b1_err got=%h exp=0", err_tid_switch); end
    rsp_tdata = 80'h32;
    rsp_ttid = 6'd7;
    tick();
    total++; if (rsp_tgtid !== 6'd7) begin bad++; $display("FAIL tid_b2_tgtid got=%0d exp=7", rsp_tgtid); end
    total++; if (err_tid_switch !== 1'b1) begin bad++; $display("FAIL tid_b2_err got=%h exp=1", err_tid_switch); end
    rsp_tdata = 80'h33;
    rsp_tlast = 1'b1;
    tick();
    rsp_tvalid = 1'b0;
    tick();
    tick();
    total++; if (err_tid_switch !== 1'b1) begin bad++; $display("FAIL tid_sticky got=%h exp=1", err_tid_switch); end
  endtask

  task automatic test_reset_mid();
    req_tready = 1'b0;
    rsp_ready = 1'b0;
    rsp_threshold = 1'b1;
    req_valid = 1'b1;
    req_payload = {80'h77, 10'h3FF};
    req_srcid = 6'd1;
    req_last = 1'b0;
    rsp_tvalid = 1'b1;
    rsp_tdata = 80'h88;
    rsp_ttid = 6'd1;
    rsp_tlast = 1'b0;
    tick();
    tick();
    req_valid = 1'b0;
    rsp_tvalid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rm_req_full got=%h exp=0", req_ready); end
    total++; if (rsp_tready !== 1'b0) begin bad++; $display("FAIL rm_rsp_full got=%h exp=0", rsp_tready); end
    rst_n = 1'b0;
    tick();
    total++; if (req_tvalid !== 1'b0) begin bad++; $display("FAIL rm_req_tvalid got=%h exp=0", req_tvalid); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_rsp_valid got=%h exp=0", rsp_valid); end
    total++; if (err_tid_switch !== 1'b0) begin bad++; $display("FAIL rm_err got=%h exp=0", err_tid_switch); end
    rst_n = 1'b1;
    tick();
    rsp_threshold = 1'b0;
    rsp_tvalid = 1'b1;
    rsp_tdata = 80'hC;
    rsp_ttid = 6'd12;
    rsp_tlast = 1'b1;
    #1;
    total++; if (rsp_tready !== 1'b0) begin bad++; $display("FAIL rm_fsm_idle got=%h exp=0", rsp_tready); end
    rsp_threshold = 1'b1;
    rsp_ready = 1'b1;
    req_tready = 1'b1;
    req_valid = 1'b1;
    req_payload = {80'hD, 10'h001};
    req_srcid = 6'd6;
    req_last = 1'b1;
    tick();
    rsp_tvalid = 1'b0;
    req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rm_rsp_fresh got=%h exp=1", rsp_valid); end
    total++; if (rsp_tgtid !== 6'd12) begin bad++; $display("FAIL rm_rsp_tgtid got=%0d exp=12", rsp_tgtid); end
    total++; if (rsp_payload !== {80'hC, 10'h3FF}) begin bad++; $display("FAIL rm_rsp_data got=%h exp=%h", rsp_payload, {80'hC, 10'h3FF}); end
    total++; if (req_tvalid !== 1'b1) begin bad++; $display("FAIL rm_req_fresh got=%h exp=1", req_tvalid); end
    total++; if (req_tdata !== 80'hD) begin bad++; $display("FAIL rm_req_data got=%h exp=d", req_tdata); end
    total++; if (req_ttid !== 6'd6) begin bad++; $display("FAIL rm_req_ttid got=%0d exp=6", req_ttid); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_rsp_drain got=%h exp=0", rsp_valid); end
    total++; if (err_tid_switch !== 1'b0) begin bad++; $display("FAIL rm_err_after got=%h exp=0", err_tid_switch); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_payload = '0;
    req_srcid = '0;
    req_last = 1'b0;
    req_tready = 1'b0;
    rsp_tvalid = 1'b0;
    rsp_tdata = '0;
    rsp_tkeep = '0;
    rsp_tlast = 1'b0;
    rsp_ttid = '0;
    rsp_ready = 1'b0;
    rsp_threshold = 1'b1;
    test_reset();
    test_single_req();
    test_rsp_4beat();
    test_backpressure();
    test_threshold();
    test_tid_switch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gnpd_to_dti_conv.md
Name: gnpd_to_dti_conv

Overview:
- Target-side endpoint of the DTI-over-GNPD path. Sits between the NoC GNPD port at the TCU node and the TCU DTI AXI-stream port.
- Request direction: unpacks GNPD flits (payload = {tdata[79:0], tkeep[9:0]}, srcid = originating master) into DTI stream beats, with ttid = srcid.
- Response direction: packs TCU DTI beats into GNPD flits, routing each on tgtid = ttid.
- Both directions are registered through 2-entry skid buffers. The response direction also gates packet start on NoC threshold and checks packet integrity.

Parameters:
NODE_ID, 0, 6-bit srcid driven on every response flit (this node's NoC id)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  GNPD request flit valid
req_ready  out  1  GNPD request flit accept
req_payload  in  90  {tdata, tkeep}
req_srcid  in  6  originating master id
req_last  in  1  last flit of packet
req_threshold  out  1  buffer-space hint to NoC
req_tvalid  out  1  DTI request beat valid
req_tdata  out  80  DTI data
req_tkeep  out  10  DTI byte keep
req_tlast  out  1  DTI last
req_ttid  out  6  DTI TID (= srcid)
req_tready  in  1  TCU accept
rsp_tvalid  in  1  TCU response beat valid
rsp_tdata  in  80  DTI data
rsp_tkeep  in  10  DTI byte keep
rsp_tlast  in  1  DTI last
rsp_ttid  in  6  destination master id
rsp_tready  out  1  accept from TCU
rsp_valid  out  1  GNPD response flit valid
rsp_ready  in  1  NoC accept
rsp_payload  out  90  {tdata, tkeep}
rsp_srcid  out  6  NODE_ID
rsp_tgtid  out  6  = captured ttid
rsp_qos  out  1  tied 1
rsp_last  out  1  = tlast
rsp_threshold  in  1  NoC permits new response packet
err_tid_switch  out  1  sticky: ttid/srcid changed mid-packet

Behaviour:
- Reset (rst_n=0 at posedge): both skid buffers emptied; all valids 0; req_ready=0, rsp_tready=0 during reset; req_threshold=0; err_tid_switch=0; rsp FSM=IDLE; all data outputs 0. Reset mid-packet discards buffered beats without completing the packet.
- Skid buffer (each direction), 2 entries, main and skid:
  - Output driven from the main register only. Zero combinational path from input to output.
  - ready_out = !skid_full, registered.
  - Accepting into a full main register while the output stalls goes to skid. Skid drains to main on the next output handshake.
  - Latency 1 cycle when empty. Sustained 1 beat/cycle when downstream is ready.
  - Simultaneous push and pop with only main full: main is replaced, occupancy unchanged.
- Request path: req_tdata = payload[89:10]; req_tkeep = payload[9:0]; req_ttid = srcid; req_tlast = req_last. The whole set is captured atomically per flit.
- req_threshold = 1 iff request-buffer occupancy == 0 (registered, updated with occupancy).
- Response FSM (input side, gating rsp_tready):
  - IDLE: rsp_tready = !skid_full && rsp_threshold. On a handshake: capture ttid into cur_tid. If tlast=1, stay in IDLE (single-beat packet); otherwise go to PKT.
  - PKT: rsp_tready = !skid_full; rsp_threshold is ignored, so a packet is never split by threshold. On a handshake with tlast=1, go to IDLE.
  - In PKT, a beat with ttid != cur_tid: beat still forwarded with tgtid = its own ttid; err_tid_switch set (sticky until reset).
- Request path integrity: the same check runs on req_srcid across a non-last flit sequence. It sets the same err_tid_switch.
- rsp_srcid = NODE_ID and rsp_qos = 1 at all times after reset.
- No beat is dropped, duplicated or reordered in either direction. Valid, once asserted, is held with stable data until ready.

Test Plan:
- Single-flit request, payload = {80'hA5.., 10'h3FF}, srcid = 6'd5, last = 1, req_tready = 1 -> one cycle later: req_tvalid = 1, tdata = 80'hA5.., tkeep = 10'h3FF, ttid = 5, tlast = 1. req_threshold falls for 1 cycle.
- 4-beat response, ttid = 9, rsp_ready = 1 -> 4 flits back-to-back: tgtid = 9, srcid = NODE_ID, rsp_last only on the 4th flit, err_tid_switch = 0.
- Backpressure: req_tready = 0 for 5 cycles during a 6-flit stream -> exactly 2 flits accepted, then req_ready = 0. On release, all 6 beats are emitted in order with no loss or duplication.
- Threshold gating: rsp_threshold = 0 in IDLE -> rsp_tready = 0. Drop rsp_threshold after beat 1 of a 3-beat packet -> beats 2 and 3 are still accepted. A new packet waits for rsp_threshold = 1.
- Response ttid changes 3 -> 7 on beat 2 of a 3-beat packet -> beat forwarded with tgtid = 7, err_tid_switch = 1 and holding.
- Assert rst_n = 0 with both buffers full mid-packet -> next cycle: all valids 0, err_tid_switch = 0, FSM in IDLE. After release, a fresh 1-beat packet passes with 1-cycle latency.
